// File: rtl/audio_clk_pkg.sv
// rtl/audio_clk_pkg.sv - shared types and sizing helpers for the audio clock sequencer
package audio_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_WARMUP    = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int OVERRUN_W = 16;

  function automatic int frame_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/audio_clk_divider.sv
// rtl/audio_clk_divider.sv - mclk/bclk/lrclk divider chain with frame-complete strobe
module audio_clk_divider #(
  parameter int mclk_half     = 5,
  parameter int bclk_ratio    = 2,
  parameter int bits_per_half = 32
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic run,
  output logic mclk,
  output logic bclk,
  output logic lrclk,
  output logic frame_done
);

  localparam int MW = $clog2(mclk_half);
  localparam int RW = (bclk_ratio > 1) ? $clog2(bclk_ratio) : 1;
  localparam int BW = (bits_per_half > 1) ? $clog2(bits_per_half) : 1;
  localparam logic [MW-1:0] M_LAST = MW'(mclk_half - 1);
  localparam logic [RW-1:0] R_LAST = RW'(bclk_ratio - 1);
  localparam logic [BW-1:0] B_LAST = BW'(bits_per_half - 1);

  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic mclk_q, mclk_d, bclk_q, bclk_d, lrclk_q, lrclk_d;
  logic mclk_tog, bclk_tog, bclk_fall, lrclk_tog;

  // frame_done is combinational so the FSM can act on the same edge lrclk falls
  always_comb begin
    mclk_tog   = run && (mcnt_q == M_LAST);
    bclk_tog   = mclk_tog && (rcnt_q == R_LAST);
    bclk_fall  = bclk_tog && bclk_q;
    lrclk_tog  = bclk_fall && (bcnt_q == B_LAST);
    frame_done = lrclk_tog && lrclk_q;
    mcnt_d  = mcnt_q;
    rcnt_d  = rcnt_q;
    bcnt_d  = bcnt_q;
    mclk_d  = mclk_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    if (!run) begin
      mcnt_d  = '0;
      rcnt_d  = '0;
      bcnt_d  = '0;
      mclk_d  = 1'b0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
    end else begin
      mcnt_d = mclk_tog ? '0 : mcnt_q + 1'b1;
      if (mclk_tog) begin
        mclk_d = ~mclk_q;
        rcnt_d = (rcnt_q == R_LAST) ? '0 : rcnt_q + 1'b1;
      end
      if (bclk_tog)  bclk_d  = ~bclk_q;
      if (bclk_fall) bcnt_d  = (bcnt_q == B_LAST) ? '0 : bcnt_q + 1'b1;
      if (lrclk_tog) lrclk_d = ~lrclk_q;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mcnt_q  <= '0;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      mclk_q  <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      mcnt_q  <= mcnt_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      mclk_q  <= mclk_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign mclk  = mclk_q;
  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

endmodule

// File: rtl/audio_clock_sequencer.sv
// rtl/audio_clock_sequencer.sv - codec bring-up FSM, warm-up frame counter and rx tick/overrun logic
module audio_clock_sequencer
  import audio_clk_pkg::*;
#(
  parameter int mclk_half     = 5,
  parameter int bclk_ratio    = 2,
  parameter int bits_per_half = 32,
  parameter int settle_frames = 4
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 pll_lock,
  input  logic                 enable,
  input  logic                 rx_valid,
  input  logic                 engine_ready,
  output logic                 mclk,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 codec_en,
  output logic                 tick_engine,
  output logic                 overrun,
  output logic [OVERRUN_W-1:0] overrun_count,
  output logic [1:0]           state
);

  localparam int FW = frame_cnt_w(settle_frames);
  localparam logic [FW-1:0] LAST_FRAME = FW'(settle_frames - 1);

  state_e state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [OVERRUN_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic rx_prev_q, rx_prev_d, tick_q, tick_d, ovr_q, ovr_d, codec_en_q, codec_en_d;
  logic up, run, frame_done, rx_edge;

  assign up  = pll_lock && enable;
  // Gating with `up` stops the clocks on the same edge that samples lock loss
  assign run = up && (state_q != ST_WAIT_LOCK);

  audio_clk_divider #(
    .mclk_half    (mclk_half),
    .bclk_ratio   (bclk_ratio),
    .bits_per_half(bits_per_half)
  ) u_div (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .run       (run),
    .mclk      (mclk),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .frame_done(frame_done)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    ovr_cnt_d = ovr_cnt_q;
    rx_edge   = (state_q == ST_RUN) && up && rx_valid && !rx_prev_q;
    tick_d    = rx_edge && engine_ready;
    ovr_d     = rx_edge && !engine_ready;
    rx_prev_d = (state_q == ST_RUN) && rx_valid;
    if (ovr_d && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + 1'b1;
    if (!up) begin
      state_d = ST_WAIT_LOCK;
      frame_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          state_d = ST_WARMUP;
          frame_d = '0;
        end
        ST_WARMUP: begin
          if (frame_done) begin
            if (frame_q == LAST_FRAME) state_d = ST_RUN;
            else                       frame_d = frame_q + 1'b1;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
    codec_en_d = (state_d != ST_WAIT_LOCK);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT_LOCK;
      frame_q    <= '0;
      ovr_cnt_q  <= '0;
      rx_prev_q  <= 1'b0;
      tick_q     <= 1'b0;
      ovr_q      <= 1'b0;
      codec_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      ovr_cnt_q  <= ovr_cnt_d;
      rx_prev_q  <= rx_prev_d;
      tick_q     <= tick_d;
      ovr_q      <= ovr_d;
      codec_en_q <= codec_en_d;
    end
  end

  assign codec_en      = codec_en_q;
  assign tick_engine   = tick_q;
  assign overrun       = ovr_q;
  assign overrun_count = ovr_cnt_q;
  assign state         = state_q;

endmodule
